fetch_ctrl: RTL and testbench

Sequencer for the instruction-bus side of the fetch stage. It turns the fetch PC into a well-formed ibus transaction and holds `valid`/`addr` stable until `data_ok`. It discards responses orphaned by a redirect and buffers the returned instruction until decode accepts it. It sits between the PC register and decode, replacing ad-hoc valid generation with a registered FSM.

---
 rtl/common_pkg.sv | 21 ++
 rtl/pipes_pkg.sv | 18 +
 rtl/fetch_ctrl.sv | 122 ++++++++++++
 tb/tb_fetch_ctrl.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/common_pkg.sv
// Shared scalar aliases and instruction-bus transaction types.
package common;

    typedef logic [31:0] u32;
    typedef logic [63:0] u64;

    // Instruction-bus request. The fetch sequencer drives only valid and addr.
    typedef struct packed {
        logic       valid;
        u64         addr;
        logic [2:0] size;
        logic [7:0] strobe;
    } ibus_req_t;

    // Instruction-bus response: completion strobe plus the 32-bit word.
    typedef struct packed {
        logic data_ok;
        u32   data;
    } ibus_resp_t;

endpackage

// File: rtl/pipes_pkg.sv
// Pipeline-stage control types shared between front-end sequencers.
package pipes;

    // IDLE: nothing in flight. REQ: live request. DROP: request orphaned by a
    // redirect, waiting only to swallow its response. HOLD: word buffered for decode.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2,
        HOLD = 2'd3
    } fetch_state_t;

    // Instructions are 4-byte aligned; any low PC bit set is a fetch fault.
    function automatic logic pc_misaligned(input logic [1:0] pc_lo);
        return pc_lo != 2'b00;
    endfunction

endpackage

// File: rtl/fetch_ctrl.sv
// Fetch-stage ibus sequencer: launches one request at a time, keeps it stable
// until data_ok, swallows responses orphaned by a redirect and buffers the
// returned word (or a misalignment fault) until decode takes it.
module fetch_ctrl
    import common::*;
    import pipes::*;
#(
    parameter u64 RESET_ADDR = 64'h0
) (
    input  logic       clk,
    input  logic       reset,
    input  u64         pc,
    input  logic       fetch_en,
    input  logic       redirect,
    input  logic       dbus_busy,
    input  logic       dec_ready,
    output ibus_req_t  ireq,
    input  ibus_resp_t iresp,
    output logic       instr_valid,
    output u32         instr,
    output u64         instr_pc,
    output logic       instr_err,
    output logic       stallF
);

    fetch_state_t state_q;
    u64           addr_q;
    u32           instr_q;
    u64           pc_q;
    logic         err_q;

    // A new launch may start only when upstream allows it and the shared bus is free.
    logic launch_ok;
    logic pc_bad;
    assign launch_ok = fetch_en && !dbus_busy;
    assign pc_bad    = pc_misaligned(pc[1:0]);

    // Sequencer state and datapath registers; REQ/DROP never leave before data_ok
    // except via reset, so the bus request is never withdrawn.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= RESET_ADDR;
            instr_q <= '0;
            pc_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (launch_ok && !redirect) begin
                        if (pc_bad) begin
                            instr_q <= '0;
                            pc_q    <= pc;
                            err_q   <= 1'b1;
                            state_q <= HOLD;
                        end else begin
                            addr_q  <= pc;
                            state_q <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (iresp.data_ok) begin
                        if (redirect) begin
                            state_q <= IDLE;
                        end else begin
                            instr_q <= iresp.data;
                            pc_q    <= addr_q;
                            err_q   <= 1'b0;
                            state_q <= HOLD;
                        end
                    end else if (redirect) begin
                        state_q <= DROP;
                    end
                end
                DROP: begin
                    if (iresp.data_ok) begin
                        state_q <= IDLE;
                    end
                end
                HOLD: begin
                    if (redirect) begin
                        err_q   <= 1'b0;
                        state_q <= IDLE;
                    end else if (dec_ready) begin
                        if (launch_ok && pc_bad) begin
                            instr_q <= '0;
                            pc_q    <= pc;
                            err_q   <= 1'b1;
                            state_q <= HOLD;
                        end else if (launch_ok) begin
                            addr_q  <= pc;
                            err_q   <= 1'b0;
                            state_q <= REQ;
                        end else begin
                            err_q   <= 1'b0;
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Bus request decoded from registered state; unused request fields tied off.
    always_comb begin
        ireq       = '0;
        ireq.valid = (state_q == REQ) || (state_q == DROP);
        ireq.addr  = addr_q;
    end

    // The PC register advances only when decode consumes the buffered entry.
    always_comb begin
        instr_valid = (state_q == HOLD);
        instr       = instr_q;
        instr_pc    = pc_q;
        instr_err   = err_q;
        stallF      = !((state_q == HOLD) && dec_ready && !redirect);
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed table, hand sequences for
// redirect/reset corners, and randomized traffic against a reference model.
module tb_fetch_ctrl;
    import common::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    u64         pc = '0;
    logic       fetch_en = 1'b0;
    logic       redirect = 1'b0;
    logic       dbus_busy = 1'b0;
    logic       dec_ready = 1'b0;
    ibus_req_t  ireq;
    ibus_resp_t iresp;
    logic       instr_valid;
    u32         instr;
    u64         instr_pc;
    logic       instr_err;
    logic       stallF;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    fetch_ctrl #(.RESET_ADDR(64'h0)) dut (
        .clk         (clk),
        .reset       (reset),
        .pc          (pc),
        .fetch_en    (fetch_en),
        .redirect    (redirect),
        .dbus_busy   (dbus_busy),
        .dec_ready   (dec_ready),
        .ireq        (ireq),
        .iresp       (iresp),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_err   (instr_err),
        .stallF      (stallF)
    );

    typedef struct {
        logic fe; u64 pc; logic rd; logic bsy; logic dr; logic dok; u32 data;
        logic e_iv; u64 e_ia; logic e_inv; u32 e_ins; u64 e_ipc; logic e_err; logic e_stall;
    } vec_t;

    typedef struct {
        u32   ins;
        u64   ipc;
        logic err;
    } ent_t;

    // Reference model: one outstanding-request flag, a stale flag, a 1-deep buffer.
    logic m_out;
    logic m_stale;
    u64   m_addr;
    ent_t mq[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic fe, input u64 p, input logic rd, input logic bsy,
                         input logic dr, input logic dok, input u32 d);
        fetch_en      = fe;
        pc            = p;
        redirect      = rd;
        dbus_busy     = bsy;
        dec_ready     = dr;
        iresp.data_ok = dok;
        iresp.data    = d;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic vec_t mk(logic fe, u64 p, logic rd, logic bsy, logic dr, logic dok, u32 d,
                                logic iv, u64 ia, logic inv, u32 ins, u64 ipc, logic err, logic stl);
        vec_t v;
        v.fe = fe; v.pc = p; v.rd = rd; v.bsy = bsy; v.dr = dr; v.dok = dok; v.data = d;
        v.e_iv = iv; v.e_ia = ia; v.e_inv = inv; v.e_ins = ins; v.e_ipc = ipc;
        v.e_err = err; v.e_stall = stl;
        return v;
    endfunction

    task automatic m_launch(input u64 p);
        ent_t e;
        if (p[1:0] != 2'b00) begin
            e.ins = '0; e.ipc = p; e.err = 1'b1;
            mq.push_back(e);
        end else begin
            m_out   = 1'b1;
            m_stale = 1'b0;
            m_addr  = p;
        end
    endtask

    task automatic m_step();
        ent_t e;
        if (m_out) begin
            if (iresp.data_ok) begin
                m_out = 1'b0;
                if (!m_stale && !redirect) begin
                    e.ins = iresp.data; e.ipc = m_addr; e.err = 1'b0;
                    mq.push_back(e);
                end
            end else if (redirect) begin
                m_stale = 1'b1;
            end
        end else if (mq.size() != 0) begin
            if (redirect) begin
                mq.delete();
            end else if (dec_ready) begin
                mq.delete();
                if (fetch_en && !dbus_busy) m_launch(pc);
            end
        end else if (fetch_en && !dbus_busy && !redirect) begin
            m_launch(pc);
        end
    endtask

    localparam u64 A = 64'h8000_0000;
    localparam u64 B = 64'h9000_0000;
    localparam u64 C = 64'h9000_0040;

    vec_t tbl[23];

    initial begin
        iresp = '0;
        // Directed table: one row per cycle, expected outputs before the edge.
        tbl[0]  = mk(1, A,       0,0,0,0,32'h0,        0,0,      0,32'h0,        0,      0,1);
        tbl[1]  = mk(0, A,       0,0,0,0,32'h0,        1,A,      0,32'h0,        0,      0,1);
        tbl[2]  = mk(0, A,       0,0,0,0,32'h0,        1,A,      0,32'h0,        0,      0,1);
        tbl[3]  = mk(0, A,       0,0,0,0,32'h0,        1,A,      0,32'h0,        0,      0,1);
        tbl[4]  = mk(0, A,       0,0,0,1,32'h13,       1,A,      0,32'h0,        0,      0,1);
        tbl[5]  = mk(0, A,       0,0,0,0,32'h0,        0,0,      1,32'h13,       A,      0,1);
        tbl[6]  = mk(0, A,       0,0,0,0,32'h0,        0,0,      1,32'h13,       A,      0,1);
        tbl[7]  = mk(0, A,       0,0,0,0,32'h0,        0,0,      1,32'h13,       A,      0,1);
        tbl[8]  = mk(0, A,       0,0,0,0,32'h0,        0,0,      1,32'h13,       A,      0,1);
        tbl[9]  = mk(0, A,       0,0,0,0,32'h0,        0,0,      1,32'h13,       A,      0,1);
        tbl[10] = mk(1, A+4,     0,1,1,0,32'h0,        0,0,      1,32'h13,       A,      0,0);
        tbl[11] = mk(0, A+4,     0,0,0,0,32'h0,        0,0,      0,32'h0,        0,      0,1);
        tbl[12] = mk(1, A+2,     0,0,0,0,32'h0,        0,0,      0,32'h0,        0,      0,1);
        tbl[13] = mk(0, A+2,     0,0,0,0,32'h0,        0,0,      1,32'h0,        A+2,    1,1);
        tbl[14] = mk(1, A+4,     0,0,1,0,32'h0,        0,0,      1,32'h0,        A+2,    1,0);
        tbl[15] = mk(0, A+4,     0,0,0,1,32'hDEADBEEF, 1,A+4,    0,32'h0,        0,      0,1);
        tbl[16] = mk(0, A+4,     1,0,0,0,32'h0,        0,0,      1,32'hDEADBEEF, A+4,    0,1);
        tbl[17] = mk(1, A+8,     1,0,0,0,32'h0,        0,0,      0,32'h0,        0,      0,1);
        tbl[18] = mk(1, A+'h100, 0,0,0,0,32'h0,        0,0,      0,32'h0,        0,      0,1);
        tbl[19] = mk(0, A+'h100, 0,0,0,0,32'h0,        1,A+'h100,0,32'h0,        0,      0,1);
        tbl[20] = mk(0, A+'h100, 1,0,0,1,32'hCAFE,     1,A+'h100,0,32'h0,        0,      0,1);
        tbl[21] = mk(0, A,       0,0,0,0,32'h0,        0,0,      0,32'h0,        0,      0,1);
        tbl[22] = mk(0, A,       0,0,0,0,32'h0,        0,0,      0,32'h0,        0,      0,1);

        // Reset state
        #2;
        chk("rst_ivalid", ireq.valid, 1'b0);
        chk("rst_req_all", ireq, '0);
        chk("rst_instr_valid", instr_valid, 1'b0);
        chk("rst_instr", instr, '0);
        chk("rst_instr_pc", instr_pc, '0);
        chk("rst_err", instr_err, 1'b0);
        chk("rst_stall", stallF, 1'b1);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Directed table
        for (int i = 0; i < 23; i++) begin
            drive(tbl[i].fe, tbl[i].pc, tbl[i].rd, tbl[i].bsy, tbl[i].dr, tbl[i].dok, tbl[i].data);
            #1;
            chk($sformatf("vec%0d_ivalid", i), ireq.valid, tbl[i].e_iv);
            if (tbl[i].e_iv) chk($sformatf("vec%0d_iaddr", i), ireq.addr, tbl[i].e_ia);
            chk($sformatf("vec%0d_instr_valid", i), instr_valid, tbl[i].e_inv);
            if (tbl[i].e_inv) begin
                chk($sformatf("vec%0d_instr", i), instr, tbl[i].e_ins);
                chk($sformatf("vec%0d_instr_pc", i), instr_pc, tbl[i].e_ipc);
                chk($sformatf("vec%0d_err", i), instr_err, tbl[i].e_err);
            end
            chk($sformatf("vec%0d_stall", i), stallF, tbl[i].e_stall);
            $display("vec %0d: ivalid=%0b addr=%h instr_valid=%0b instr=%h stallF=%0b",
                     i, ireq.valid, ireq.addr, instr_valid, instr, stallF);
            next_cycle();
        end

        // Redirect mid-wait: orphaned response swallowed, next launch uses new pc
        drive(1, B, 0,0,0,0, 0); #1; chk("drop_c0_iv", ireq.valid, 1'b0); next_cycle();
        drive(0, B, 0,0,0,0, 0); #1; chk("drop_c1_iv", ireq.valid, 1'b1);
        chk("drop_c1_addr", ireq.addr, B); next_cycle();
        drive(0, C, 1,0,0,0, 0); #1; chk("drop_c2_iv", ireq.valid, 1'b1);
        chk("drop_c2_addr", ireq.addr, B); next_cycle();
        drive(0, C, 1,0,0,0, 0); #1; chk("drop_c3_iv", ireq.valid, 1'b1);
        chk("drop_c3_addr", ireq.addr, B); chk("drop_c3_inv", instr_valid, 1'b0); next_cycle();
        drive(0, C, 0,0,0,1, 32'h55); #1; chk("drop_c4_iv", ireq.valid, 1'b1);
        chk("drop_c4_addr", ireq.addr, B); chk("drop_c4_inv", instr_valid, 1'b0); next_cycle();
        drive(1, C, 0,0,0,0, 0); #1; chk("drop_c5_iv", ireq.valid, 1'b0);
        chk("drop_c5_inv", instr_valid, 1'b0); next_cycle();
        drive(0, C, 0,0,0,0, 0); #1; chk("drop_c6_iv", ireq.valid, 1'b1);
        chk("drop_c6_addr", ireq.addr, C); next_cycle();
        drive(0, C, 0,0,0,1, 32'h77); #1; chk("drop_c7_iv", ireq.valid, 1'b1); next_cycle();
        drive(0, C, 0,0,1,0, 0); #1; chk("drop_c8_inv", instr_valid, 1'b1);
        chk("drop_c8_instr", instr, 32'h77); chk("drop_c8_ipc", instr_pc, C); next_cycle();
        drive(0, C, 0,0,0,0, 0); #1; chk("drop_c9_inv", instr_valid, 1'b0);
        $display("drop sequence done");
        next_cycle();

        // Reset asserted mid-REQ drops the request immediately
        drive(1, A, 0,0,0,0, 0); next_cycle();
        drive(0, A, 0,0,0,0, 0); #1; chk("rstreq_iv_before", ireq.valid, 1'b1);
        reset = 1'b1; #1;
        chk("rstreq_iv_async", ireq.valid, 1'b0);
        chk("rstreq_stall", stallF, 1'b1);
        chk("rstreq_inv", instr_valid, 1'b0);
        next_cycle();
        reset = 1'b0; #1;
        chk("rstrel_iv", ireq.valid, 1'b0);
        chk("rstrel_inv", instr_valid, 1'b0);
        chk("rstrel_stall", stallF, 1'b1);
        next_cycle();
        #1; chk("rstrel_idle_iv", ireq.valid, 1'b0);
        $display("reset-mid-request sequence done");

        // Randomized traffic vs reference model, from a clean reset
        reset = 1'b1; #1; reset = 1'b0;
        m_out = 1'b0; m_stale = 1'b0; m_addr = '0; mq.delete();
        next_cycle();
        for (int n = 0; n < 3000; n++) begin
            u64 rp;
            rp = A + (64'(urandom_range_w(1023)) << 2);
            if ($urandom_range(0, 7) == 0) rp = rp + 64'($urandom_range(1, 3));
            drive($urandom_range(0, 3) != 0, rp, $urandom_range(0, 9) == 0,
                  $urandom_range(0, 4) == 0, 1'($urandom_range(0, 1)),
                  $urandom_range(0, 2) == 0, $urandom);
            #1;
            chk("rnd_ivalid", ireq.valid, m_out);
            if (m_out) chk("rnd_iaddr", ireq.addr, m_addr);
            chk("rnd_instr_valid", instr_valid, mq.size() != 0);
            if (mq.size() != 0) begin
                chk("rnd_instr", instr, mq[0].ins);
                chk("rnd_instr_pc", instr_pc, mq[0].ipc);
                chk("rnd_err", instr_err, mq[0].err);
                if (dec_ready && !redirect)
                    $display("rnd %0d: delivered pc=%h instr=%h err=%0b", n, mq[0].ipc, mq[0].ins, mq[0].err);
            end
            chk("rnd_stall", stallF, !((mq.size() != 0) && dec_ready && !redirect));
            m_step();
            next_cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    function automatic int unsigned urandom_range_w(input int unsigned hi);
        return $urandom_range(0, hi);
    endfunction

endmodule
